// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a small byte FIFO
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DONE_AT  = 16'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [2:0]    next_idx;
    logic [15:0]   baud;
    logic          wr;
    logic          pop;
    logic          bit_end;

    assign o_TX_Ready = o_Fifo_Count != CW'(FIFO_DEPTH);
    assign wr         = i_TX_DV && o_TX_Ready;
    assign pop        = state == IDLE && o_Fifo_Count != '0;
    assign bit_end    = baud == BIT_LAST;
    assign next_idx   = bit_idx + 3'd1;

    // byte storage; only written slots are ever read, so no reset is needed
    always_ff @(posedge i_Clk) begin
        if (wr) mem[wr_ptr] <= i_TX_Byte;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_Fifo_Count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            o_Fifo_Count <= o_Fifo_Count + CW'(wr) - CW'(pop);
        end
    end

    // frame sequencer with registered line, active and done outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
            baud        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
        end else begin
            o_TX_Done <= 1'b0;
            case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift       <= mem[rd_ptr];
                        state       <= START;
                        o_TX_Serial <= 1'b0;
                        o_TX_Active <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud        <= '0;
                        state       <= DATA;
                        o_TX_Serial <= shift[0];
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state       <= STOP;
                            o_TX_Serial <= 1'b1;
                        end else begin
                            bit_idx     <= next_idx;
                            o_TX_Serial <= shift[next_idx];
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud        <= '0;
                        bit_idx     <= '0;
                        state       <= IDLE;
                        o_TX_Active <= 1'b0;
                    end else begin
                        baud      <= baud + 16'd1;
                        o_TX_Done <= baud == DONE_AT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench with a cycle-level occupancy/frame-timing model
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       ready;
    logic       serial;
    logic       active;
    logic       done;
    logic [2:0] count;

    int checks = 0;
    int passed = 0;

    int mcount = 0;
    int busy   = 0;
    logic [7:0] exp_q[$];

    bit acc;
    bit do_pop;

    logic [39:0] smp;
    int          sn = 0;
    bit          in_frame = 0;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_TX_DV(dv),
        .i_TX_Byte(din),
        .o_TX_Ready(ready),
        .o_TX_Serial(serial),
        .o_TX_Active(active),
        .o_TX_Done(done),
        .o_Fifo_Count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: a byte queue drained one frame at a time, each frame
    // occupying the line for FRAME cycles plus one idle cycle before the next pop
    always @(posedge clk) begin
        if (rst) begin
            mcount = 0;
            busy   = 0;
            exp_q.delete();
        end else begin
            acc    = dv && mcount < DEPTH;
            do_pop = busy == 0 && mcount > 0;
            if (busy > 0) busy--;
            if (do_pop) begin
                mcount--;
                busy = FRAME;
            end
            if (acc) begin
                mcount++;
                exp_q.push_back(din);
            end
        end
    end

    // monitor: per-cycle status against the model, plus frame decoding against the scoreboard
    initial forever begin
        @(posedge clk);
        #2;
        chk("count", 32'(count), 32'(mcount));
        chk("ready", 32'(ready), 32'(mcount != DEPTH));
        chk("active", 32'(active), 32'(busy > 0));
        chk("done", 32'(done), 32'(busy == 1));
        if (busy == 0) chk("idle_line", 32'(serial), 32'd1);
        if (rst) begin
            in_frame = 0;
        end else if (in_frame || active) begin
            if (!in_frame) begin
                in_frame = 1;
                sn = 0;
            end
            smp[sn] = serial;
            sn++;
            if (sn == FRAME) begin
                logic       fmt_ok;
                logic [7:0] got;
                logic [3:0] seg;
                fmt_ok = smp[3:0] == 4'h0 && smp[39:36] == 4'hF;
                for (int i = 0; i < 8; i++) begin
                    seg = smp[4 + 4 * i +: 4];
                    if (seg != 4'h0 && seg != 4'hF) fmt_ok = 0;
                    got[i] = seg[0];
                end
                chk("frame_fmt", 32'(fmt_ok), 32'd1);
                if (exp_q.size() == 0) chk("frame_unexpected", 32'(got), 32'hFFFF_FFFF);
                else chk("frame_byte", 32'(got), 32'(exp_q.pop_front()));
                in_frame = 0;
            end
        end
    end

    task automatic put(input logic [7:0] b);
        dv  = 1'b1;
        din = b;
        @(negedge clk);
    endtask

    task automatic release_dv();
        dv  = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_serial", 32'(serial), 32'd1);
        chk("rst_active", 32'(active), 32'd0);
        rst = 1'b0;
        idle(5);
        chk("no_frame_after_rst", 32'(active), 32'd0);

        put(8'hA5);
        release_dv();
        idle(50);

        put(8'h01);
        put(8'h02);
        put(8'h03);
        release_dv();
        idle(3 * (FRAME + 1) + 10);

        for (int i = 0; i < 6; i++) put(8'(8'h10 + i));
        release_dv();
        idle(5 * (FRAME + 1) + 10);

        for (int i = 0; i < 5; i++) put(8'(8'h20 + i));
        release_dv();
        for (int i = 0; i < 200 && !(busy == 0 && mcount == DEPTH); i++) @(negedge clk);
        chk("wait_full_pop", 32'(busy == 0 && mcount == DEPTH), 32'd1);
        put(8'hEE);
        release_dv();
        chk("coinc_count", 32'(count), 32'd3);
        idle(4 * (FRAME + 1) + 10);

        put(8'h3C);
        put(8'hC3);
        put(8'h5A);
        release_dv();
        for (int i = 0; i < 200 && busy != FRAME - 18; i++) @(negedge clk);
        chk("wait_bit3", 32'(busy), 32'(FRAME - 18));
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("async_serial", 32'(serial), 32'd1);
        chk("async_active", 32'(active), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(100);

        put(8'hFF);
        put(8'h00);
        release_dv();
        idle(2 * (FRAME + 1) + 10);

        repeat (400) begin
            dv  = $urandom_range(0, 5) == 0;
            din = 8'($urandom);
            @(negedge clk);
        end
        release_dv();

        for (int i = 0; i < 500 && !(mcount == 0 && busy == 0); i++) @(negedge clk);
        idle(5);
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
